// File: rtl/print_number_fmt.sv
// Formats a latched unsigned value as decimal (double-dabble) or hex ASCII digits plus an optional CR/LF, streamed one byte at a time to the UART.
// Latency: WIDTH (dec) or 1 (hex) conversion cycles, then one byte per tx_start/tx_busy handshake; bytes stall in SEND while tx_busy is high.
module print_number_fmt #(
    parameter int WIDTH        = 16,
    parameter int DEC_DIGITS   = 5,
    parameter int TERM         = 2,
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    input  logic             hex_mode,
    input  logic             suppress_zeros,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic             busy,
    output logic             done
);
    localparam int HEX_DIGITS = (WIDTH + 3) / 4;
    localparam int MAXD       = (DEC_DIGITS > HEX_DIGITS) ? DEC_DIGITS : HEX_DIGITS;
    localparam int DB         = DEC_DIGITS * 4;
    localparam int IW         = $clog2(MAXD + 1);
    localparam int CW         = $clog2(WIDTH + 1);
    localparam int TW         = $clog2(BUSY_TIMEOUT + 2);

    typedef enum logic [3:0] {
        S_IDLE, S_CONVERT, S_SELECT, S_SEND, S_WAIT_HI,
        S_WAIT_LO, S_NEXT, S_TERM_SEL, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              start_q;
    logic [WIDTH-1:0]  val_q, val_d;
    logic              hex_q, hex_d, sup_q, sup_d, nz_q, nz_d;
    logic [MAXD*4-1:0] dig_q, dig_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [1:0]        term_q, term_d;
    logic [TW-1:0]     to_q, to_d;
    logic              tx_start_q, tx_start_d, busy_q, busy_d, done_q, done_d;
    logic [7:0]        tx_data_q, tx_data_d;

    logic [DB-1:0]     bcd;
    logic [3:0]        cur_dig;
    logic [IW-1:0]     msd_idx;
    logic              start_edge;

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

    assign start_edge = start & ~start_q;
    assign cur_dig    = dig_q[{idx_q, 2'b00} +: 4];
    assign msd_idx    = hex_q ? IW'(HEX_DIGITS - 1) : IW'(DEC_DIGITS - 1);

    // One double-dabble step; the top-digit carry falls off, giving mod 10^DEC_DIGITS.
    always_comb begin
        bcd = dig_q[DB-1:0];
        for (int i = 0; i < DEC_DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) bcd[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        bcd = {bcd[DB-2:0], val_q[WIDTH-1]};
    end

    always_comb begin
        state_d    = state_q;
        val_d      = val_q;
        hex_d      = hex_q;
        sup_d      = sup_q;
        nz_d       = nz_q;
        dig_d      = dig_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        term_d     = term_q;
        to_d       = to_q;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        tx_start_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    val_d   = value;
                    hex_d   = hex_mode;
                    sup_d   = suppress_zeros;
                    nz_d    = 1'b0;
                    dig_d   = '0;
                    cnt_d   = '0;
                    term_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (hex_q) begin
                    dig_d             = '0;
                    dig_d[WIDTH-1:0]  = val_q;
                    idx_d             = msd_idx;
                    state_d           = S_SELECT;
                end else begin
                    dig_d          = '0;
                    dig_d[DB-1:0]  = bcd;
                    val_d          = val_q << 1;
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        idx_d   = msd_idx;
                        state_d = S_SELECT;
                    end
                end
            end
            S_SELECT: begin
                if (sup_q && cur_dig == 4'd0 && idx_q != '0 && !nz_q) begin
                    idx_d = idx_q - 1'b1;
                end else begin
                    tx_data_d = to_ascii(cur_dig);
                    if (cur_dig != 4'd0) nz_d = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    to_d       = '0;
                    state_d    = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (tx_busy)                          state_d = S_WAIT_LO;
                else if (to_q == TW'(BUSY_TIMEOUT))   state_d = S_NEXT;
                else                                  to_d    = to_q + 1'b1;
            end
            S_WAIT_LO: begin
                if (!tx_busy) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q != '0) begin
                    idx_d   = idx_q - 1'b1;
                    state_d = S_SELECT;
                end else begin
                    state_d = S_TERM_SEL;
                end
            end
            S_TERM_SEL: begin
                if (int'(term_q) < TERM) begin
                    tx_data_d = (TERM == 2 && term_q == 2'd0) ? 8'h0D : 8'h0A;
                    term_d    = term_q + 1'b1;
                    state_d   = S_SEND;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            val_q      <= '0;
            hex_q      <= 1'b0;
            sup_q      <= 1'b0;
            nz_q       <= 1'b0;
            dig_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            term_q     <= '0;
            to_q       <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h30;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            val_q      <= val_d;
            hex_q      <= hex_d;
            sup_q      <= sup_d;
            nz_q       <= nz_d;
            dig_q      <= dig_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            term_q     <= term_d;
            to_q       <= to_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_print_number_fmt.sv
// Scoreboard bench: three formatter instances (default, 3-digit/LF, no terminator) each driving a small UART model.
`timescale 1ns/1ps
module tb_print_number_fmt;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  start_v, hexm, supz;
    logic [15:0] val [3];
    logic [1:0]  umode [3];
    wire  [2:0]  txs, bsy, dn, txb;
    wire  [7:0]  txd [3];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [8:0] q0[$], q1[$], q2[$];
    int pulse_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    print_number_fmt u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .value(val[0]), .hex_mode(hexm[0]),
        .suppress_zeros(supz[0]), .tx_busy(txb[0]), .tx_start(txs[0]), .tx_data(txd[0]),
        .busy(bsy[0]), .done(dn[0]));
    print_number_fmt #(.DEC_DIGITS(3), .TERM(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .value(val[1]), .hex_mode(hexm[1]),
        .suppress_zeros(supz[1]), .tx_busy(txb[1]), .tx_start(txs[1]), .tx_data(txd[1]),
        .busy(bsy[1]), .done(dn[1]));
    print_number_fmt #(.TERM(0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .value(val[2]), .hex_mode(hexm[2]),
        .suppress_zeros(supz[2]), .tx_busy(txb[2]), .tx_start(txs[2]), .tx_data(txd[2]),
        .busy(bsy[2]), .done(dn[2]));

    // UART model: mode 0 busy for 10 cycles per byte, 1 stuck low, 2 stuck high.
    for (genvar g = 0; g < 3; g++) begin : g_uart
        logic b = 1'b0;
        int   c = 0;
        always @(posedge clk) begin
            if (umode[g] == 2'd1) begin
                b <= 1'b0; c <= 0;
            end else if (umode[g] == 2'd2) begin
                b <= 1'b1;
            end else if (txs[g]) begin
                b <= 1'b1; c <= 10;
            end else if (c > 0) begin
                c <= c - 1; b <= (c > 1);
            end else begin
                b <= 1'b0;
            end
        end
        assign txb[g] = b;
    end

    task automatic pushq(input int g, input logic [8:0] e);
        case (g)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int g);
        case (g)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push(input int g, input string s, input int term);
        for (int i = 0; i < s.len(); i++) pushq(g, {1'b0, s[i]});
        if (term == 2) pushq(g, 9'h00D);
        if (term >= 1) pushq(g, 9'h00A);
        pushq(g, 9'h100);
    endtask

    // 9'h100 marks a done pulse in the expected stream.
    task automatic sb_check(input int g, input logic [8:0] got);
        logic [8:0] ev;
        bit have;
        have = 0;
        ev   = '0;
        case (g)
            0: if (q0.size() > 0) begin ev = q0.pop_front(); have = 1; end
            1: if (q1.size() > 0) begin ev = q1.pop_front(); have = 1; end
            default: if (q2.size() > 0) begin ev = q2.pop_front(); have = 1; end
        endcase
        n_tests++;
        if (!have) begin
            n_fail++;
            $display("FAIL sb%0d unexpected event got=%h required=none", g, got);
        end else if (got !== ev) begin
            n_fail++;
            $display("FAIL sb%0d event got=%h required=%h", g, got, ev);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (txs[g]) begin
                sb_check(g, {1'b0, txd[g]});
                if (g == 0) pulse_cyc.push_back(cyc);
            end
            if (dn[g]) sb_check(g, 9'h100);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got=%0h required=%0h", nm, got, req);
        end
    endtask

    task automatic run(input int g, input logic [15:0] v, input logic h, input logic s);
        @(negedge clk);
        val[g] = v; hexm[g] = h; supz[g] = s; start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g, input int budget, input string nm);
        int n;
        n = 0;
        while ((qsize(g) != 0 || bsy[g] !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_complete"}, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; start_v = '0; hexm = '0; supz = '0;
        for (int i = 0; i < 3; i++) begin val[i] = '0; umode[i] = 2'd0; end
        repeat (3) @(negedge clk);
        chk("rst_tx_start", 32'(txs[0]), 32'd0);
        chk("rst_tx_data",  32'(txd[0]), 32'h30);
        chk("rst_busy",     32'(bsy[0]), 32'd0);
        chk("rst_done",     32'(dn[0]),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        push(0, "00123", 2); run(0, 16'd123, 1'b0, 1'b0);   wait_idle(0, 2000, "dec123");
        push(0, "0", 2);     run(0, 16'd0, 1'b0, 1'b1);     wait_idle(0, 2000, "dec0_sup");
        push(0, "65535", 2); run(0, 16'hFFFF, 1'b0, 1'b1);  wait_idle(0, 2000, "dec65535");
        push(0, "BEEF", 2);  run(0, 16'hBEEF, 1'b1, 1'b0);  wait_idle(0, 2000, "hexBEEF");
        push(1, "234", 1);   run(1, 16'd1234, 1'b0, 1'b0);  wait_idle(1, 2000, "dec3_wrap");
        push(1, "A", 1);     run(1, 16'h000A, 1'b1, 1'b1);  wait_idle(1, 2000, "hexA_lf");
        push(2, "BEEF", 0);  run(2, 16'hBEEF, 1'b1, 1'b0);  wait_idle(2, 2000, "hex_noterm");

        // Start held high: exactly one run.
        push(0, "42", 2);
        @(negedge clk);
        val[0] = 16'd42; hexm[0] = 1'b0; supz[0] = 1'b1; start_v[0] = 1'b1;
        repeat (500) @(negedge clk);
        start_v[0] = 1'b0;
        wait_idle(0, 200, "hold");

        // Second edge mid-run with a different value is ignored.
        push(0, "00314", 2);
        run(0, 16'd314, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        val[0] = 16'd999; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_idle(0, 2000, "midrun");

        // tx_busy stuck low: each byte waits out the timeout.
        umode[0] = 2'd1;
        @(negedge clk);
        pulse_cyc.delete();
        push(0, "7", 2);
        run(0, 16'd7, 1'b0, 1'b1);
        wait_idle(0, 6000, "timeout");
        chk("timeout_pulses", 32'(pulse_cyc.size()), 32'd3);
        if (pulse_cyc.size() >= 3) begin
            chk("timeout_gap1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd1027);
            chk("timeout_gap2", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd1027);
        end

        // tx_busy stuck high: no byte ever requested.
        umode[0] = 2'd2;
        @(negedge clk);
        pulse_cyc.delete();
        run(0, 16'd5, 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        chk("stuck_busy",   32'(bsy[0]), 32'd1);
        chk("stuck_pulses", 32'(pulse_cyc.size()), 32'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        umode[0] = 2'd0;
        repeat (5) @(negedge clk);

        // Reset during the third byte's WAIT_LO.
        pulse_cyc.delete();
        pushq(0, {1'b0, 8'h30}); pushq(0, {1'b0, 8'h30}); pushq(0, {1'b0, 8'h31});
        run(0, 16'd123, 1'b0, 1'b0);
        n = 0;
        while (pulse_cyc.size() < 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_third_byte", 32'(n < 1000), 32'd1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tx_start", 32'(txs[0]), 32'd0);
        chk("midrst_busy",     32'(bsy[0]), 32'd0);
        chk("midrst_done",     32'(dn[0]),  32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("midrst_no_more_bytes", 32'(pulse_cyc.size()), 32'd3);
        chk("midrst_queue_drained", 32'(qsize(0)), 32'd0);
        push(0, "00123", 2);
        run(0, 16'd123, 1'b0, 1'b0);
        wait_idle(0, 2000, "after_rst");

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/print_number_fmt.md
Name: print_number_fmt

Overview:
Parametrised formatter that turns a latched unsigned value into ASCII digits (decimal or hex) plus an optional line terminator and streams the bytes to the shared UART transmitter over the tx_start/tx_busy handshake. It is the general-purpose successor to the fixed 3-digit cycle printer. It sits after the matrix print stage and prints engine counters of any width. Decimal conversion is iterative (shift-add-3), so no divider is inferred.

Parameters:
WIDTH, 16, bit width of value.
DEC_DIGITS, 5, decimal digits produced (1..10). The value is printed modulo 10^DEC_DIGITS.
TERM, 2, terminator: 0 none, 1 LF (0x0A), 2 CR LF (0x0D 0x0A).
BUSY_TIMEOUT, 1023, cycles to wait for tx_busy to rise after tx_start before the byte is treated as sent.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  a rising edge begins one print run
value  in  WIDTH  number to print; sampled on the start edge
hex_mode  in  1  1 = hex, 0 = decimal; sampled on the start edge
suppress_zeros  in  1  1 = skip leading zeros; sampled on the start edge
tx_busy  in  1  UART transmitter busy
tx_start  out  1  one-cycle byte request to the UART
tx_data  out  8  byte to transmit; registered
busy  out  1  high from the accepted start edge until done
done  out  1  one-cycle pulse at the end of a run

Behaviour:
- Reset: state IDLE; tx_start=0, tx_data=0x30, busy=0, done=0; all counters and shift registers cleared. Reset mid-run aborts the run immediately, and no further bytes are emitted.
- start is edge-detected with a registered copy that resets to 0. Holding start high never retriggers a run. A start edge while busy=1 is ignored.
- HEX_DIGITS = ceil(WIDTH/4). Hex uses uppercase A-F. The value is zero-extended to a whole number of nibbles.
- States: IDLE -> CONVERT -> SELECT -> SEND -> WAIT_HI -> WAIT_LO -> NEXT -> (SELECT | TERM_SEL) ... -> DONE -> IDLE.
- IDLE: on the start edge, latch value, hex_mode and suppress_zeros, set busy=1, go to CONVERT.
- CONVERT:
  - Decimal: exactly WIDTH cycles of double-dabble into a DEC_DIGITS x 4-bit BCD register. Each cycle adds 3 to every digit >= 5, then shifts left one bit, bringing in the next value MSB. The top-digit carry is discarded, which gives modulo 10^DEC_DIGITS.
  - Hex: one cycle.
  - Then the digit index is set to the most significant digit and the state goes to SELECT.
- SELECT (one cycle per skipped digit): if suppress_zeros=1, the current digit is 0, it is not the least significant digit, and no nonzero digit has been sent yet, advance the index and stay in SELECT. Otherwise load tx_data with the ASCII digit and go to SEND. The least significant digit is always printed.
- SEND: wait while tx_busy=1. When tx_busy=0, assert tx_start for exactly one cycle, clear the timeout counter, go to WAIT_HI.
- WAIT_HI: when tx_busy=1, go to WAIT_LO. If the counter reaches BUSY_TIMEOUT first, go to NEXT (byte assumed consumed).
- WAIT_LO: when tx_busy=0, go to NEXT.
- tx_data is held stable from SEND until NEXT.
- NEXT:
  - If more digits remain, decrement the index and go to SELECT.
  - Else, if terminator bytes remain (per TERM), load 0x0D or 0x0A in that order and go to SEND.
  - Else go to DONE.
- DONE: done=1 for one cycle, busy=0 on the following cycle, return to IDLE. A new start edge is accepted from the IDLE cycle onward.
- Bytes per run:
  - Decimal: (DEC_DIGITS, or fewer when suppressed) + TERM count.
  - Hex: HEX_DIGITS (or fewer when suppressed) + TERM count.
- A run must never emit two tx_start pulses without an intervening WAIT_HI/WAIT_LO sequence or timeout.

Test Plan:
- Decimal, value=123, suppress=0, defaults, UART model busy for 10 cycles per byte -> bytes "00123" 0x0D 0x0A, 7 tx_start pulses, then one done pulse.
- value=0, suppress=1 -> "0" CR LF. value=65535, suppress=1 -> "65535" CR LF. DEC_DIGITS=3, value=1234 -> "234" CR LF (modulo wrap).
- hex_mode=1, value=0xBEEF -> "BEEF" CR LF. value=0x000A, suppress=1, TERM=1 -> "A" LF. TERM=0 -> no terminator and done follows the last digit.
- Hold start high for 500 cycles, and pulse start again mid-run with a different value -> exactly one run, output matches the value latched at the first edge.
- tx_busy stuck at 0 -> each byte advances after BUSY_TIMEOUT+1 cycles in WAIT_HI, and the run completes with done. tx_busy stuck at 1 -> tx_start never asserts, busy stays 1.
- Assert rst_n low during the third byte's WAIT_LO -> tx_start, busy and done go to 0 immediately, no bytes after release, and the next start edge prints the full string from the first digit.
